uart_tx_arbiter: RTL

Shares the single UART transmitter among N_REQ byte-stream requesters (debug, status, config readback). Grants whole packets round-robin and frames each one as header byte, payload, XOR checksum. Drives the UART in_valid/in_data/in_ready byte interface directly and sits between the requesters and the UART instance.

---
 rtl/uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one UART transmitter among N_REQ byte-stream requesters. Whole
//   packets are granted round-robin. Each packet goes out as
//       header (8'hA0 | grant_id), payload bytes, XOR checksum
//   where the checksum is the XOR of the header and every payload byte.
//   A packet is cut short after MAX_LEN payload bytes if the requester has not
//   marked one of them as last. len_err pulses when that happens.
//
// Ports:
//   main_clk       system clock
//   reset          asynchronous, active-high reset
//   req_valid[i]   requester i presents a byte
//   req_data       requester i byte on bits [8i+7:8i]
//   req_last[i]    presented byte is the last payload byte of the packet
//   req_ready[i]   one-cycle pulse: requester i byte consumed
//   uart_in_ready  UART transmitter idle
//   uart_in_valid  one-cycle byte-load strobe to the UART
//   uart_in_data   byte to the UART, held until the next strobe
//   busy           packet in progress
//   grant_id       granted requester, meaningful while busy
//   len_err        one-cycle pulse: packet truncated at MAX_LEN
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MAX_LEN = 64
) (
    input  logic                 main_clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 uart_in_ready,
    output logic                 uart_in_valid,
    output logic [7:0]           uart_in_data,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    // Width of the rotating search index; one spare bit so rr_ptr + offset
    // never overflows before the wrap correction.
    localparam int SW = ID_W + 1;

    state_t             state_q,      state_d;
    logic [ID_W-1:0]    rr_ptr_q,     rr_ptr_d;
    logic [ID_W-1:0]    grant_q,      grant_d;
    logic [7:0]         csum_q,       csum_d;
    logic [7:0]         count_q,      count_d;
    logic               holdoff_q,    holdoff_d;
    logic               uart_valid_q, uart_valid_d;
    logic [7:0]         uart_data_q,  uart_data_d;
    logic [N_REQ-1:0]   req_ready_q,  req_ready_d;
    logic               len_err_q,    len_err_d;
    logic               busy_q,       busy_d;

    // Per-requester byte lanes.
    logic [7:0] req_byte [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    logic [7:0] grant_byte;
    logic       grant_valid;
    logic       grant_last;

    assign grant_byte  = req_byte[grant_q];
    assign grant_valid = req_valid[grant_q];
    assign grant_last  = req_last[grant_q];

    // Round-robin pick: first valid requester at offset 0, 1, ... from
    // rr_ptr. Scanning offsets downward lets the smallest offset win.
    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic [SW-1:0]   cand_sum;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr_q} + SW'(k);
            if (cand_sum >= SW'(N_REQ)) begin
                cand_sum = cand_sum - SW'(N_REQ);
            end
            cand_idx = cand_sum[ID_W-1:0];
            if (req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // The UART reports ready for one more cycle after it latches a byte, so
    // a new load is blocked in the strobe cycle and in the holdoff cycle that
    // follows it. Blocking in the strobe cycle also keeps the current byte
    // from being consumed twice while the requester is still presenting it.
    logic issue_ok;
    assign issue_ok = uart_in_ready && !holdoff_q && !uart_valid_q;

    logic [7:0]      header_byte;
    logic [3:0]      header_id;
    logic [ID_W-1:0] grant_next;

    assign header_id   = 4'(grant_q);
    assign header_byte = 8'hA0 | {4'h0, header_id};
    assign grant_next  = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        csum_d       = csum_q;
        count_d      = count_q;
        holdoff_d    = uart_valid_q;
        uart_valid_d = 1'b0;
        uart_data_d  = uart_data_q;
        req_ready_d  = '0;
        len_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    csum_d  = 8'h00;
                    count_d = 8'h00;
                    state_d = HDR;
                end
            end

            HDR: begin
                if (issue_ok) begin
                    uart_valid_d = 1'b1;
                    uart_data_d  = header_byte;
                    csum_d       = header_byte;
                    state_d      = DATA;
                end
            end

            DATA: begin
                // A stalled requester keeps the grant; nothing re-arbitrates
                // until its packet is closed.
                if (issue_ok && grant_valid) begin
                    uart_valid_d = 1'b1;
                    uart_data_d  = grant_byte;
                    req_ready_d  = N_REQ'(1) << grant_q;
                    csum_d       = csum_q ^ grant_byte;
                    count_d      = count_q + 8'd1;
                    if (grant_last) begin
                        state_d = CSUM;
                    end else if (count_q == 8'(MAX_LEN - 1)) begin
                        // Any remaining bytes of this requester form a new
                        // packet after the checksum.
                        state_d   = CSUM;
                        len_err_d = 1'b1;
                    end
                end
            end

            CSUM: begin
                if (issue_ok) begin
                    uart_valid_d = 1'b1;
                    uart_data_d  = csum_q;
                    rr_ptr_d     = grant_next;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            csum_q       <= 8'h00;
            count_q      <= 8'h00;
            holdoff_q    <= 1'b0;
            uart_valid_q <= 1'b0;
            uart_data_q  <= 8'h00;
            req_ready_q  <= '0;
            len_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            csum_q       <= csum_d;
            count_q      <= count_d;
            holdoff_q    <= holdoff_d;
            uart_valid_q <= uart_valid_d;
            uart_data_q  <= uart_data_d;
            req_ready_q  <= req_ready_d;
            len_err_q    <= len_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign uart_in_valid = uart_valid_q;
    assign uart_in_data  = uart_data_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;
    assign len_err       = len_err_q;

endmodule
